// File: rtl/naughty_q_param.sv
// naughty_q_param: indexed circular FIFO ("NaughtyQ" gen 2) behind an
// enable/ready/command/crashed handshake. Entries are addressed by physical
// slot index, so callers can enlist, delist, read and overwrite by index.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   enable, ready    command strobe; accepted on a rising edge with both high
//   command          opcode (0 NOP,1 ENLIST,2 DELIST,3 READ,4 WRITE,5 CLEAR,7 PEEK)
//   idx_in, data_in  operands for READ/WRITE/ENLIST
//   idx_out,data_out results; hold until the next response that defines them
//   resp_valid       one-cycle pulse when a command completes
//   crashed          sticky error flag, cleared only by reset
//   count            occupancy 0..DEPTH
//
// Build option: define NAUGHTY_Q_PEEK_EN to make opcode 7 (PEEK) legal;
// otherwise opcode 7 crashes like any other illegal opcode.
module naughty_q_param #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              ready,
  output logic              crashed,
  input  logic [3:0]        command,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [IDX_W-1:0]  idx_out,
  output logic [DATA_W-1:0] data_out,
  output logic              resp_valid,
  output logic [IDX_W:0]    count
);
  localparam int DEPTH = 2**IDX_W;
  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE = 1;
  localparam logic [IDX_W-1:0] PTR_ONE = 1;

  localparam logic [3:0] OP_NOP = 4'd0, OP_ENLIST = 4'd1, OP_DELIST = 4'd2,
                         OP_READ = 4'd3, OP_WRITE = 4'd4, OP_CLEAR = 4'd5,
                         OP_PEEK = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_CRASH} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [IDX_W-1:0]    idx_out_q, idx_out_d, pend_idx_q, pend_idx_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                resp_valid_q, resp_valid_d;
  logic                ready_q, ready_d, crashed_q, crashed_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data_q;
  logic                mem_we, rd_en;
  logic [IDX_W-1:0]    mem_addr;

  logic                accept, occupied, full, empty;
  logic [IDX_W-1:0]    rel;

  assign accept   = enable && ready_q && !reset;
  // Slot distance from head in ring order; occupied if inside the live window.
  assign rel      = idx_in - head_q;
  assign occupied = {1'b0, rel} < count_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    idx_out_d  = idx_out_q;
    data_out_d = data_out_q;
    pend_idx_d = pend_idx_q;
    mem_we     = 1'b0;
    rd_en      = 1'b0;
    mem_addr   = head_q;

    case (state_q)
      S_IDLE: if (accept) begin
        case (command)
          OP_NOP: state_d = S_RESP;
          OP_ENLIST: if (full) state_d = S_CRASH;
            else begin
              mem_we    = 1'b1;
              mem_addr  = tail_q;
              idx_out_d = tail_q;
              tail_d    = tail_q + PTR_ONE;
              count_d   = count_q + CNT_ONE;
              state_d   = S_RESP;
            end
          // Read pre-increment head now; head/count move on this same edge.
          OP_DELIST: if (empty) state_d = S_CRASH;
            else begin
              rd_en      = 1'b1;
              mem_addr   = head_q;
              pend_idx_d = head_q;
              head_d     = head_q + PTR_ONE;
              count_d    = count_q - CNT_ONE;
              state_d    = S_BUSY;
            end
          OP_READ: if (!occupied) state_d = S_CRASH;
            else begin
              rd_en      = 1'b1;
              mem_addr   = idx_in;
              pend_idx_d = idx_in;
              state_d    = S_BUSY;
            end
          OP_WRITE: if (!occupied) state_d = S_CRASH;
            else begin
              mem_we    = 1'b1;
              mem_addr  = idx_in;
              idx_out_d = idx_in;
              state_d   = S_RESP;
            end
          OP_CLEAR: begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = S_RESP;
          end
`ifdef NAUGHTY_Q_PEEK_EN
          OP_PEEK: if (empty) state_d = S_CRASH;
            else begin
              rd_en      = 1'b1;
              mem_addr   = head_q;
              pend_idx_d = head_q;
              state_d    = S_BUSY;
            end
`endif
          default: state_d = S_CRASH;
        endcase
      end
      S_BUSY: begin
        data_out_d = rd_data_q;
        idx_out_d  = pend_idx_q;
        state_d    = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_CRASH;
    endcase

    // Handshake outputs are registered copies of the next state.
    resp_valid_d = (state_d == S_RESP);
    ready_d      = (state_d == S_IDLE);
    crashed_d    = (state_d == S_CRASH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      idx_out_q    <= '0;
      data_out_q   <= '0;
      pend_idx_q   <= '0;
      resp_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      crashed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      idx_out_q    <= idx_out_d;
      data_out_q   <= data_out_d;
      pend_idx_q   <= pend_idx_d;
      resp_valid_q <= resp_valid_d;
      ready_q      <= ready_d;
      crashed_q    <= crashed_d;
    end
  end

  // Storage: no reset needed, occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= data_in;
    if (rd_en)  rd_data_q     <= mem[mem_addr];
  end

  assign ready      = ready_q;
  assign crashed    = crashed_q;
  assign idx_out    = idx_out_q;
  assign data_out   = data_out_q;
  assign resp_valid = resp_valid_q;
  assign count      = count_q;
endmodule

// File: tb/tb_naughty_q_param.sv
module tb_naughty_q_param;
  logic       clk = 0, reset = 1, enable = 0;
  logic [3:0] command = 0, idx_in = 0;
  logic [7:0] data_in = 0;
  logic       ready, crashed, resp_valid;
  logic [3:0] idx_out;
  logic [7:0] data_out;
  logic [4:0] count;

  naughty_q_param #(.DATA_W(8), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ready(ready), .crashed(crashed),
    .command(command), .idx_in(idx_in), .data_in(data_in), .idx_out(idx_out),
    .data_out(data_out), .resp_valid(resp_valid), .count(count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  // Command-level model: queue contents, pointers and expected visible outputs.
  logic [7:0] m_mem [16];
  int m_head = 0, m_tail = 0, m_count = 0;
  bit exp_crashed = 0, exp_ready = 0, exp_resp = 0;
  logic [3:0] exp_idx = 0;
  logic [7:0] exp_data = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("count", count, m_count);
    chk("crashed", crashed, exp_crashed);
    chk("ready", ready, exp_ready);
    chk("resp_valid", resp_valid, exp_resp);
    chk("idx_out", idx_out, exp_idx);
    chk("data_out", data_out, exp_data);
  end

  function automatic bit occ(input int i);
    return ((i - m_head + 16) % 16) < m_count;
  endfunction

  task automatic model_clear_all();
    m_head = 0; m_tail = 0; m_count = 0;
    exp_crashed = 0; exp_ready = 0; exp_resp = 0; exp_idx = 0; exp_data = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; enable = 0;
    @(posedge clk); #1 model_clear_all(); chk_en = 1;
    @(negedge clk); reset = 0;
    @(posedge clk); #1 exp_ready = 1;
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [3:0] idx, input logic [7:0] d);
    int n = 0;
    bit legal, rd;
    logic [3:0] nidx;
    logic [7:0] ndata;
    legal = 0; rd = 0; nidx = exp_idx; ndata = exp_data;
    if (exp_crashed) begin
      // Stuck: strobe anyway, nothing must change.
      @(negedge clk); enable = 1; command = op; idx_in = idx; data_in = d;
      @(posedge clk); #1 enable = 0;
      return;
    end
    @(negedge clk);
    while (!ready && n < 20) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready=%0b expected 1", ready);
      return;
    end
    enable = 1; command = op; idx_in = idx; data_in = d;
    @(posedge clk); #1 enable = 0;
    case (op)
      4'd0: legal = 1;
      4'd1: legal = m_count < 16;
      4'd2: begin legal = m_count > 0; rd = 1; end
      4'd3: begin legal = occ(idx); rd = 1; end
      4'd4: legal = occ(idx);
      4'd5: legal = 1;
`ifdef NAUGHTY_Q_PEEK_EN
      4'd7: begin legal = m_count > 0; rd = 1; end
`endif
      default: legal = 0;
    endcase
    if (!legal) begin exp_crashed = 1; exp_ready = 0; return; end
    case (op)
      4'd1: begin m_mem[m_tail] = d; nidx = 4'(m_tail); m_tail = (m_tail + 1) % 16; m_count++; end
      4'd2: begin ndata = m_mem[m_head]; nidx = 4'(m_head); m_head = (m_head + 1) % 16; m_count--; end
      4'd3: begin ndata = m_mem[idx]; nidx = idx; end
      4'd4: begin m_mem[idx] = d; nidx = idx; end
      4'd5: begin m_head = 0; m_tail = 0; m_count = 0; end
      4'd7: begin ndata = m_mem[m_head]; nidx = 4'(m_head); end
      default: ;
    endcase
    exp_ready = 0;
    if (!rd) begin
      exp_resp = 1; exp_idx = nidx;
      @(posedge clk); #1 exp_resp = 0; exp_ready = 1;
    end else begin
      @(posedge clk); #1 exp_resp = 1; exp_idx = nidx; exp_data = ndata;
      @(posedge clk); #1 exp_resp = 0; exp_ready = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int r;
    logic [3:0] op, ix;
    do_reset();
    chk("rst_ready", ready, 1);
    chk("rst_count", count, 0);

    // Basic enlist/delist order
    do_cmd(1, 0, 8'h11); chk("enq0_idx", idx_out, 0);
    do_cmd(1, 0, 8'h22); chk("enq1_idx", idx_out, 1);
    do_cmd(1, 0, 8'h33); chk("enq2_idx", idx_out, 2);
    chk("cnt3", count, 3);
    do_cmd(2, 0, 0); chk("deq0_data", data_out, 8'h11); chk("deq0_idx", idx_out, 0);
    do_cmd(2, 0, 0); chk("deq1_data", data_out, 8'h22); chk("deq1_idx", idx_out, 1);
    do_cmd(2, 0, 0); chk("deq2_data", data_out, 8'h33); chk("deq2_idx", idx_out, 2);
    chk("cnt0", count, 0);

    // Fill, overflow crash, ignored while crashed, reset recovers
    for (int i = 0; i < 16; i++) do_cmd(1, 0, 8'(i));
    chk("cnt16", count, 16);
    do_cmd(1, 0, 8'hEE);
    chk("ovf_crashed", crashed, 1); chk("ovf_ready", ready, 0); chk("ovf_cnt", count, 16);
    do_cmd(5, 0, 0);
    do_reset();
    chk("rec_crashed", crashed, 0); chk("rec_cnt", count, 0);

    // Underflow and unoccupied read
    do_cmd(2, 0, 0); chk("uf_crashed", crashed, 1);
    do_reset();
    do_cmd(1, 0, 8'hA0); do_cmd(1, 0, 8'hA1);
    do_cmd(3, 5, 0); chk("rd5_crashed", crashed, 1);
    do_reset();

    // Overwrite by index
    do_cmd(1, 0, 8'h01); do_cmd(1, 0, 8'h02); do_cmd(1, 0, 8'h03);
    do_cmd(4, 1, 8'hAB); chk("wr_idx", idx_out, 1);
    do_cmd(3, 1, 0); chk("rd1_data", data_out, 8'hAB);
    do_cmd(2, 0, 0); do_cmd(2, 0, 0); chk("deq_wr_data", data_out, 8'hAB);
    do_reset();

    // Wrap-around
    for (int i = 0; i < 14; i++) do_cmd(1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 14; i++) do_cmd(2, 0, 0);
    do_cmd(1, 0, 8'hC0); chk("wr14", idx_out, 14);
    do_cmd(1, 0, 8'hC1); chk("wr15", idx_out, 15);
    do_cmd(1, 0, 8'hC2); chk("wr0", idx_out, 0);
    do_cmd(1, 0, 8'hC3); chk("wr1", idx_out, 1);
    do_cmd(3, 0, 0); chk("wrd0_data", data_out, 8'hC2); chk("wrd0_crash", crashed, 0);
    do_cmd(3, 13, 0); chk("wrd13_crash", crashed, 1);
    do_reset();

    // Opcode 7 and an illegal opcode
    do_cmd(1, 0, 8'h5A);
    do_cmd(7, 0, 0);
`ifdef NAUGHTY_Q_PEEK_EN
    chk("peek_data", data_out, 8'h5A); chk("peek_cnt", count, 1);
`else
    chk("op7_crash", crashed, 1);
`endif
    do_reset();
    do_cmd(1, 0, 8'h5A);
    do_cmd(9, 0, 0); chk("op9_crash", crashed, 1);
    do_reset();

    // Reset in the middle of a read-class command: no response, queue empty
    do_cmd(1, 0, 8'h77);
    @(negedge clk); enable = 1; command = 2;
    @(posedge clk); #1 enable = 0; m_count = 0; exp_ready = 0;
    reset = 1;
    @(posedge clk); #1 model_clear_all();
    @(negedge clk); reset = 0;
    @(posedge clk); #1 exp_ready = 1;
    repeat (3) @(negedge clk);
    chk("abort_cnt", count, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if (exp_crashed) do_reset();
      r = $urandom_range(0, 99);
      if      (r < 32) op = 1;
      else if (r < 52) op = 2;
      else if (r < 66) op = 3;
      else if (r < 78) op = 4;
      else if (r < 81) op = 5;
      else if (r < 85) op = 0;
      else if (r < 92) op = 7;
      else if (r < 94) op = 4'($urandom_range(8, 15));
      else if (r < 95) op = 6;
      else             op = 1;
      if ($urandom_range(0, 9) == 0) ix = 4'($urandom_range(0, 15));
      else ix = 4'((m_head + $urandom_range(0, (m_count > 0) ? m_count - 1 : 0)) % 16);
      do_cmd(op, ix, 8'($urandom));
    end
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/naughty_q_param.md
Name: naughty_q_param

Overview:
- Parametrised indexed FIFO ("NaughtyQ" generation 2) behind the enable/ready/command/crashed handshake used by the Kiwi-lifted NaughtyQ wrappers.
- Entries live in a circular buffer of 2**IDX_W slots. Each entry is addressed by its physical slot index, so a caller can enlist, delist, read and overwrite entries by index.
- Illegal operations latch a sticky crashed flag that blocks further commands until reset.
- Sits between NaaS packet-processing logic and its per-flow buffer state.

Parameters:
- DATA_W, 8, width of each stored entry
- IDX_W, 4, slot index width; depth DEPTH = 2**IDX_W (16 by default)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  command strobe; a command is accepted on a rising edge where enable && ready
- ready  out  1  high only in IDLE
- crashed  out  1  sticky error flag
- command  in  4  opcode
- idx_in  in  IDX_W  slot index operand for READ/WRITE
- data_in  in  DATA_W  data operand for ENLIST/WRITE
- idx_out  out  IDX_W  slot index result
- data_out  out  DATA_W  data result
- resp_valid  out  1  one-cycle pulse marking a completed command
- count  out  IDX_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: clk and reset as already decided (reset synchronous, active-high; clock clk). All outputs are 0 during reset: ready=0, crashed=0, idx_out=0, data_out=0, resp_valid=0, count=0. head=tail=0 and FSM=IDLE. ready rises on the first clock after reset deasserts.
- Reset mid-operation aborts the command in flight: no resp_valid, and the queue is emptied.
- Opcodes:
  - 0 NOP
  - 1 ENLIST: write data_in at tail; idx_out=tail; tail++; count++
  - 2 DELIST: data_out=mem[head]; idx_out=head; head++; count--
  - 3 READ: data_out=mem[idx_in]; idx_out=idx_in
  - 4 WRITE: mem[idx_in]=data_in; idx_out=idx_in
  - 5 CLEAR: head=tail=count=0
  - 7 PEEK: optional, see below
  - 6 and 8-15 are illegal
- Occupancy: slot i is occupied iff ((i - head) mod DEPTH) < count. Evaluate with IDX_W-bit wrap subtraction widened to IDX_W+1 bits for the compare.
- Pointers head and tail are IDX_W bits and wrap DEPTH-1 -> 0.
- FSM states: IDLE, BUSY, RESP, CRASH.
  - IDLE: on accept, ENLIST/WRITE/CLEAR/NOP update state and go to RESP. DELIST/READ/PEEK issue a synchronous RAM read and go to BUSY.
  - BUSY: one cycle, captures the RAM data, then RESP.
  - RESP: resp_valid=1, idx_out/data_out valid, then IDLE.
  - Latency from the accept edge to resp_valid is 1 cycle for write-class commands and 2 cycles for read-class commands. Throughput is one command per 2 or 3 cycles.
- idx_out and data_out hold their last value until the next response. Commands that do not define a field leave it unchanged.
- Errors: any of the following sends the FSM to CRASH with crashed=1, ready=0, no resp_valid and no state change:
  - ENLIST when count==DEPTH
  - DELIST or PEEK when count==0
  - READ or WRITE on an unoccupied idx_in
  - an illegal opcode
- CRASH is exited only by reset. enable is ignored while ready=0.
- count is registered and updates on the same edge as the pointers.
- In BUSY, DELIST reads the pre-increment head; head advances on the accept edge.

Optional Feature:
- NAUGHTY_Q_PEEK_EN defined: opcode 7 PEEK returns data_out=mem[head], idx_out=head and leaves head and count unchanged. Read-class, 2-cycle latency; crashes if the queue is empty.
- Macro undefined: opcode 7 is illegal and crashes.

Test Plan:
- Reset, ENLIST 0x11, 0x22, 0x33 -> idx_out 0,1,2 and count=3. Then DELIST x3 -> data_out 0x11, 0x22, 0x33 with idx_out 0,1,2; count=0; resp_valid 2 cycles after each accept.
- ENLIST 16 values 0x00-0x0F -> count=16. A 17th ENLIST -> crashed=1, ready=0, no resp_valid, count stays 16. Assert reset -> crashed=0, count=0.
- DELIST on an empty queue after reset -> crashed=1. Separately, READ idx_in=5 with count=2 (slots 0,1) -> crashed=1.
- ENLIST x3, WRITE idx 1 data 0xAB, READ idx 1 -> data_out=0xAB. DELIST x2 -> second DELIST returns 0xAB.
- Wrap-around: ENLIST 14 values, DELIST 14, then ENLIST 4 values -> idx_out 14, 15, 0, 1. READ idx 0 succeeds; READ idx 13 crashes.
- Opcode 7 with 1 entry (0x5A): with NAUGHTY_Q_PEEK_EN -> data_out=0x5A, count stays 1. Without the macro -> crashed=1. Opcode 9 -> crashed=1 in both builds.
